// File: rtl/wb_sram_slave.sv
// Pipelined Wishbone B4 slave fronting a word-addressed synchronous RAM.
// Latency: ack/err is sampled LATENCY edges after the accept edge; one response per cycle.
// Backpressure: stall_o rises once MAX_OUTST requests are unanswered (macro WB_SRAM_ERR_EN enables err on bad addresses).
module wb_sram_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 3,
    parameter int MAX_OUTST  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [ADDR_WIDTH-1:0]   wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_wdat_i,
    input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
    output logic [DATA_WIDTH-1:0]   wbs_rdat_o,
    output logic                    wbs_ack_o,
    output logic                    wbs_err_o,
    output logic                    wbs_stall_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(SEL_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    // Address bits that must be zero for a well-formed request: the byte
    // offset within a word, and everything above the word index field.
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = (ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_TOP  = (ADDR_WIDTH'(1) << (OFF + IDX_W)) - ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] HI_MASK  = ~IDX_TOP;
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_OUTST);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [LATENCY-1:0]    vld_q;
    logic [LATENCY-1:0]    err_q;
    logic [LATENCY-1:0]    rd_q;
    logic [DATA_WIDTH-1:0] dat_q [LATENCY];
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    logic             acc;
    logic             bad;
    logic             req_err;
    logic             resp;
    logic [IDX_W-1:0] idx;

    assign idx  = wbs_adr_i[OFF+IDX_W-1:OFF];
    assign bad  = |(wbs_adr_i & (LOW_MASK | HI_MASK));
    assign acc  = wbs_cyc_i & wbs_stb_i & ~wbs_stall_o;
    assign resp = vld_q[LATENCY-1];

`ifdef WB_SRAM_ERR_EN
    assign req_err   = bad;
    assign wbs_err_o = resp & err_q[LATENCY-1];
    assign wbs_ack_o = resp & ~err_q[LATENCY-1];
`else
    // Bad addresses simply alias: low bits dropped, index wraps modulo DEPTH.
    logic unused_err;
    assign req_err    = 1'b0;
    assign wbs_err_o  = 1'b0;
    assign wbs_ack_o  = resp;
    assign unused_err = ^{bad, err_q[LATENCY-1]};
`endif

    // Read data only accompanies a read ack; writes and errors return zero.
    assign wbs_rdat_o  = (wbs_ack_o & rd_q[LATENCY-1]) ? dat_q[LATENCY-1] : '0;
    // Stall comes purely from state: a response leaving this cycle frees a slot.
    assign wbs_stall_o = (cnt_q == CNT_MAX) & ~resp;

    // Outstanding count: accept and retire cancel; a dropped cycle clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (!wbs_cyc_i) begin
            cnt_d = '0;
        end else if (acc && !resp) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!acc && resp) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Byte-lane writes commit at the accept edge; RAM contents survive reset.
    always_ff @(posedge clk_i) begin
        if (acc && wbs_we_i && !req_err) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (wbs_sel_i[b]) begin
                    mem_q[idx][b*8 +: 8] <= wbs_wdat_i[b*8 +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures the request (and RAM word) at accept,
    // the last stage drives the bus; cyc_i low squashes every in-flight entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            err_q <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            vld_q[0] <= acc;
            err_q[0] <= req_err;
            rd_q[0]  <= ~wbs_we_i;
            dat_q[0] <= mem_q[idx];
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k] <= wbs_cyc_i & vld_q[k-1];
                err_q[k] <= err_q[k-1];
                rd_q[k]  <= rd_q[k-1];
                dat_q[k] <= dat_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave (defaults: 32-bit, DEPTH 256, LATENCY 3, MAX_OUTST 2).
// Inputs change on the falling edge; outputs are checked on the falling edge before the next rising edge.
// Expected values are hand-computed constants and tables.
module tb_wb_sram_slave;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic [31:0] rdat;
    logic        ack;
    logic        err;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    // Pipelined burst: request addresses and per-slot expectations.
    logic [31:0] p_adr   [4] = '{32'h4, 32'h10, 32'h4, 32'h10};
    logic        p_stall [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        p_ack   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] p_rdat  [9] = '{32'h0, 32'h0, 32'h0, 32'hCAFE0001, 32'h5AADAAEF,
                                 32'h0, 32'hCAFE0001, 32'h5AADAAEF, 32'h0};

    wb_sram_slave dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_adr_i  (adr),
        .wbs_wdat_i (wdat),
        .wbs_sel_i  (sel),
        .wbs_rdat_o (rdat),
        .wbs_ack_o  (ack),
        .wbs_err_o  (err),
        .wbs_stall_o(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single request; checks no early response, the response LAT edges after accept, then quiet.
    task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic e_ack, input logic e_err, input logic [31:0] e_rdat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        tick();
        stb = 1'b0; we = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            chk({tag, "_early"}, {30'b0, ack, err}, 32'd0);
            tick();
        end
        chk({tag, "_ack"},  {31'b0, ack}, {31'b0, e_ack});
        chk({tag, "_err"},  {31'b0, err}, {31'b0, e_err});
        chk({tag, "_rdat"}, rdat, e_rdat);
        tick();
        chk({tag, "_after"}, {30'b0, ack, err}, 32'd0);
        cyc = 1'b0;
    endtask

    initial begin
        int ri;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack",   {31'b0, ack},   32'd0);
        chk("rst_err",   {31'b0, err},   32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_rdat",  rdat,           32'd0);
        rst_n = 1'b1;

        // Idle after release
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_resp",  {29'b0, ack, err, stall}, 32'd0);
            chk("idle_rdat",  rdat, 32'd0);
        end

        // Full and byte-lane writes with read-back
        xfer("wr_full",  1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0);
        xfer("rd_full",  1'b0, 32'h10, 32'h0,        4'hF, 1'b1, 1'b0, 32'hDEADBEEF);
        xfer("wr_lane1", 1'b1, 32'h10, 32'h0000AA00, 4'h2, 1'b1, 1'b0, 32'h0);
        xfer("rd_lane1", 1'b0, 32'h10, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADAAEF);
        xfer("wr_sel0",  1'b1, 32'h10, 32'h12345678, 4'h0, 1'b1, 1'b0, 32'h0);
        xfer("rd_sel0",  1'b0, 32'h10, 32'h0,        4'hF, 1'b1, 1'b0, 32'hDEADAAEF);
        xfer("wr_lane3", 1'b1, 32'h10, 32'h5A000000, 4'h8, 1'b1, 1'b0, 32'h0);
        xfer("rd_lane3", 1'b0, 32'h10, 32'h0,        4'hF, 1'b1, 1'b0, 32'h5AADAAEF);
        xfer("wr_w0",    1'b1, 32'h0,  32'h0BADF00D, 4'hF, 1'b1, 1'b0, 32'h0);
        xfer("wr_w1",    1'b1, 32'h4,  32'hCAFE0001, 4'hF, 1'b1, 1'b0, 32'h0);

        // Out-of-range and misaligned addresses
`ifdef WB_SRAM_ERR_EN
        xfer("bad_hi_wr", 1'b1, 32'h400, 32'h77777777, 4'hF, 1'b0, 1'b1, 32'h0);
        xfer("w0_kept",   1'b0, 32'h0,   32'h0,        4'hF, 1'b1, 1'b0, 32'h0BADF00D);
        xfer("bad_lo_rd", 1'b0, 32'h11,  32'h0,        4'hF, 1'b0, 1'b1, 32'h0);
`else
        xfer("alias_wr",  1'b1, 32'h400, 32'h77777777, 4'hF, 1'b1, 1'b0, 32'h0);
        xfer("alias_rd",  1'b0, 32'h0,   32'h0,        4'hF, 1'b1, 1'b0, 32'h77777777);
        xfer("misal_rd",  1'b0, 32'h11,  32'h0,        4'hF, 1'b1, 1'b0, 32'h5AADAAEF);
`endif

        // Four back-to-back reads with stb held: accepts at edges 0,1,3,4
        ri = 0;
        cyc = 1'b1; we = 1'b0; sel = 4'hF;
        for (int s = 0; s < 9; s++) begin
            if (ri < 4) begin
                stb = 1'b1;
                adr = p_adr[ri];
            end else begin
                stb = 1'b0;
            end
            chk($sformatf("pipe_stall_%0d", s), {31'b0, stall}, {31'b0, p_stall[s]});
            chk($sformatf("pipe_ack_%0d", s),   {31'b0, ack},   {31'b0, p_ack[s]});
            chk($sformatf("pipe_err_%0d", s),   {31'b0, err},   32'd0);
            chk($sformatf("pipe_rdat_%0d", s),  rdat,           p_rdat[s]);
            if (stb && !p_stall[s]) ri++;
            tick();
        end
        cyc = 1'b0; stb = 1'b0;
        tick();

        // Two reads in flight, cyc dropped for one cycle, then a fresh read
        cyc = 1'b1; stb = 1'b1; adr = 32'h4;
        tick();
        adr = 32'h10;
        chk("sq_stall0", {31'b0, stall}, 32'd0);
        tick();
        cyc = 1'b0; stb = 1'b0;
        chk("sq_stall_full", {31'b0, stall}, 32'd1);
        tick();
        chk("sq_resp0", {29'b0, ack, err, stall}, 32'd0);
        cyc = 1'b1; stb = 1'b1; adr = 32'h4;
        tick();
        stb = 1'b0;
        chk("sq_resp1", {29'b0, ack, err, stall}, 32'd0);
        tick();
        chk("sq_resp2", {29'b0, ack, err, stall}, 32'd0);
        tick();
        chk("sq_new_ack",  {31'b0, ack}, 32'd1);
        chk("sq_new_rdat", rdat, 32'hCAFE0001);
        tick();
        chk("sq_new_done", {30'b0, ack, err}, 32'd0);
        cyc = 1'b0;
        tick();

        // Reset while a write is in flight: response lost, write kept
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8; wdat = 32'hA5A5A5A5; sel = 4'hF;
        tick();
        stb = 1'b0; we = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_resp", {29'b0, ack, err, stall}, 32'd0);
        tick();
        tick();
        chk("midrst_noack", {30'b0, ack, err}, 32'd0);
        rst_n = 1'b1; cyc = 1'b0;
        tick();
        xfer("midrst_rd", 1'b0, 32'h8, 32'h0, 4'hF, 1'b1, 1'b0, 32'hA5A5A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
